// File: rtl/trigger_gen_multi_pkg.sv
// trigger_gen_multi_pkg: shared mode/state encodings and config validation for the multi-channel trigger generator
package trigger_gen_multi_pkg;
  typedef enum logic [1:0] {
    MODE_CONT    = 2'd0,
    MODE_BURST   = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;
  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_e;
  function automatic logic cfg_bad(input mode_e mode, input logic period_lt2, input logic burst_zero);
    return mode == MODE_RSVD || period_lt2 || (mode == MODE_BURST && burst_zero);
  endfunction
endpackage

// File: rtl/trigger_gen_multi_if.sv
// trigger_gen_multi_if: control, config and trigger-output bundle of the trigger generator
interface trigger_gen_multi_if #(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 32,
  parameter int BURST_W   = 16
) ();
  logic                        enable;
  logic                        sync_in;
  logic                        load_config;
  logic [1:0]                  mode;
  logic                        ext_sync_en;
  logic [BURST_W-1:0]          burst_count;
  logic [CNT_WIDTH-1:0]        pulse_period;
  logic [NUM_CH*CNT_WIDTH-1:0] pulse_width;
  logic [NUM_CH*CNT_WIDTH-1:0] phase_offset;
  logic [NUM_CH-1:0]           trigger_out;
  logic                        active;
  logic                        done;
  logic                        cfg_error;
  modport master (
    output enable, sync_in, load_config, mode, ext_sync_en, burst_count,
           pulse_period, pulse_width, phase_offset,
    input  trigger_out, active, done, cfg_error
  );
  modport slave (
    input  enable, sync_in, load_config, mode, ext_sync_en, burst_count,
           pulse_period, pulse_width, phase_offset,
    output trigger_out, active, done, cfg_error
  );
endinterface

// File: rtl/trigger_gen_multi_channel.sv
// trigger_gen_multi_channel: phase/width window compare on the shared counter plus registered pin driver
module trigger_gen_multi_channel #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [CNT_WIDTH-1:0] cnt_i,
  input  logic [CNT_WIDTH-1:0] period_i,
  input  logic [CNT_WIDTH-1:0] width_i,
  input  logic [CNT_WIDTH-1:0] phase_i,
  input  logic                 run_i,
  output logic                 trig_o
);
  logic [CNT_WIDTH-1:0] ph;
  logic [CNT_WIDTH-1:0] d;
  logic                 trig_d;
  logic                 trig_q;
  // d is the distance since this channel's phase point, so width>=period keeps it always high
  always_comb begin
    ph     = (phase_i >= period_i) ? phase_i - period_i : phase_i;
    d      = (cnt_i >= ph) ? cnt_i - ph : cnt_i + period_i - ph;
    trig_d = (d < width_i) & run_i;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) trig_q <= 1'b0;
    else         trig_q <= trig_d;
  assign trig_o = trig_q;
endmodule

// File: rtl/trigger_gen_multi.sv
// trigger_gen_multi: NUM_CH phase-offset pulse trains from one period counter with burst/one-shot modes and boundary-safe config
module trigger_gen_multi
  import trigger_gen_multi_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 32,
  parameter int BURST_W   = 16
) (
  input  logic             clk,
  input  logic             resetn,
  trigger_gen_multi_if.slave bus
);
  localparam int VW = NUM_CH * CNT_WIDTH;
  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [BURST_W-1:0]   left_q, left_d;
  logic                 sync_q, lock_q, lock_d, err_q, err_d;
  mode_e                stg_mode_q, stg_mode_d, act_mode_q, act_mode_d;
  logic [BURST_W-1:0]   stg_burst_q, stg_burst_d;
  logic [CNT_WIDTH-1:0] stg_period_q, stg_period_d, act_period_q, act_period_d;
  logic [VW-1:0]        stg_width_q, stg_width_d, act_width_q, act_width_d;
  logic [VW-1:0]        stg_phase_q, stg_phase_d, act_phase_q, act_phase_d;
  logic                 bad, load_ok, sync_rise, wrap, apply, gate;
  logic [BURST_W-1:0]   reload;
  logic [NUM_CH-1:0]    trig;
  always_comb begin
    bad          = cfg_bad(mode_e'(bus.mode), bus.pulse_period < CNT_WIDTH'(2), bus.burst_count == '0);
    load_ok      = bus.load_config & ~bad;
    err_d        = bus.load_config ? bad : err_q;
    stg_mode_d   = load_ok ? mode_e'(bus.mode) : stg_mode_q;
    stg_burst_d  = load_ok ? bus.burst_count : stg_burst_q;
    stg_period_d = load_ok ? bus.pulse_period : stg_period_q;
    stg_width_d  = load_ok ? bus.pulse_width : stg_width_q;
    stg_phase_d  = load_ok ? bus.phase_offset : stg_phase_q;
    sync_rise    = bus.sync_in & ~sync_q;
    wrap         = state_q == RUN && cnt_q == act_period_q - 1'b1;
    // a load on the wrap cycle lands in staging only, so it reaches the counter one period later
    apply        = state_q != RUN || wrap;
    act_mode_d   = apply ? stg_mode_q : act_mode_q;
    act_period_d = apply ? stg_period_q : act_period_q;
    act_width_d  = apply ? stg_width_q : act_width_q;
    act_phase_d  = apply ? stg_phase_q : act_phase_q;
    reload       = act_mode_d == MODE_BURST ? stg_burst_q : BURST_W'(1);
    state_d      = state_q;
    unique case (state_q)
      IDLE: if (!lock_q || sync_rise) state_d = (sync_rise && bus.ext_sync_en) ? RUN : ARM;
      ARM:  if (!bus.ext_sync_en || sync_rise) state_d = RUN;
      RUN:  if (wrap && act_mode_q != MODE_CONT && left_q == BURST_W'(1)) state_d = DONE;
      DONE: state_d = IDLE;
    endcase
    if (!bus.enable) state_d = IDLE;
    cnt_d  = (state_q == RUN && state_d == RUN && !wrap) ? cnt_q + 1'b1 : '0;
    left_d = (state_q != RUN && state_d == RUN) ? reload :
             wrap ? (act_mode_q == MODE_CONT ? reload : left_q - 1'b1) : left_q;
    // a finished burst stays parked in IDLE until enable drops or a fresh sync_in arrives
    lock_d = !bus.enable ? 1'b0 :
             state_q == DONE ? 1'b1 :
             (state_q == IDLE && state_d != IDLE) ? 1'b0 : lock_q;
    gate   = state_q == RUN && state_d == RUN;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      left_q       <= '0;
      sync_q       <= 1'b0;
      lock_q       <= 1'b0;
      err_q        <= 1'b0;
      stg_mode_q   <= MODE_CONT;
      act_mode_q   <= MODE_CONT;
      stg_burst_q  <= BURST_W'(1);
      stg_period_q <= CNT_WIDTH'(2);
      act_period_q <= CNT_WIDTH'(2);
      stg_width_q  <= '0;
      act_width_q  <= '0;
      stg_phase_q  <= '0;
      act_phase_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      left_q       <= left_d;
      sync_q       <= bus.sync_in;
      lock_q       <= lock_d;
      err_q        <= err_d;
      stg_mode_q   <= stg_mode_d;
      act_mode_q   <= act_mode_d;
      stg_burst_q  <= stg_burst_d;
      stg_period_q <= stg_period_d;
      act_period_q <= act_period_d;
      stg_width_q  <= stg_width_d;
      act_width_q  <= act_width_d;
      stg_phase_q  <= stg_phase_d;
      act_phase_q  <= act_phase_d;
    end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    trigger_gen_multi_channel #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
      .clk      (clk),
      .resetn   (resetn),
      .cnt_i    (cnt_q),
      .period_i (act_period_q),
      .width_i  (act_width_q[i*CNT_WIDTH +: CNT_WIDTH]),
      .phase_i  (act_phase_q[i*CNT_WIDTH +: CNT_WIDTH]),
      .run_i    (gate),
      .trig_o   (trig[i])
    );
  end
  assign bus.trigger_out = trig;
  assign bus.active      = state_q == RUN;
  assign bus.done        = state_q == DONE;
  assign bus.cfg_error   = err_q;
endmodule

// File: tb/tb_trigger_gen_multi.sv
// tb_trigger_gen_multi: scoreboard bench for trigger_gen_multi with two channels
module tb_trigger_gen_multi;
  localparam int NC = 2;
  localparam int CW = 16;
  localparam int BW = 8;
  typedef struct {
    string      tag;
    logic [3:0] exp;
  } item_t;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] obs;
  item_t      sbq[$];
  int         n_vec = 0;
  int         n_err = 0;
  trigger_gen_multi_if #(.NUM_CH(NC), .CNT_WIDTH(CW), .BURST_W(BW)) bus ();
  trigger_gen_multi #(.NUM_CH(NC), .CNT_WIDTH(CW), .BURST_W(BW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );
  always #5 clk = ~clk;
  assign obs = {bus.active, bus.done, bus.trigger_out};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic void push(input string tag, input logic act, input logic dn, input logic t1, input logic t0);
    item_t it;
    it.tag = tag;
    it.exp = {act, dn, t1, t0};
    sbq.push_back(it);
  endfunction
  function automatic void push_run(input string tag, input int k, input int per, input int w);
    push(tag, 1'b1, 1'b0, 1'b0, (k % per) >= 1 && (k % per) <= w);
  endfunction
  function automatic logic exp4(input int k);
    return (k >= 1 && k <= 3) || (k >= 10 && ((k - 10) % 20) >= 1 && ((k - 10) % 20) <= 3);
  endfunction
  task automatic drain();
    item_t it;
    while (sbq.size() > 0) begin
      it = sbq.pop_front();
      tick();
      check(it.tag, 32'(obs), 32'(it.exp));
    end
  endtask
  task automatic set_cfg(input int m, input int ext, input int bc, input int per,
                         input int w0, input int w1, input int p0, input int p1);
    bus.mode         = 2'(m);
    bus.ext_sync_en  = 1'(ext);
    bus.burst_count  = BW'(bc);
    bus.pulse_period = CW'(per);
    bus.pulse_width  = {CW'(w1), CW'(w0)};
    bus.phase_offset = {CW'(p1), CW'(p0)};
  endtask
  task automatic load(input int m, input int ext, input int bc, input int per,
                      input int w0, input int w1, input int p0, input int p1);
    set_cfg(m, ext, bc, per, w0, w1, p0, p1);
    bus.load_config = 1'b1;
    tick();
    bus.load_config = 1'b0;
  endtask
  initial begin
    bus.enable      = 1'b0;
    bus.sync_in     = 1'b0;
    bus.load_config = 1'b0;
    set_cfg(0, 0, 1, 2, 0, 0, 0, 0);
    repeat (2) tick();
    check("rst_out", 32'(obs), 32'h0);
    check("rst_err", 32'(bus.cfg_error), 32'h0);
    resetn = 1'b1;
    tick();
    // continuous, two channels with phase offset
    load(0, 0, 1, 10, 3, 5, 0, 4);
    check("cont_err", 32'(bus.cfg_error), 32'h0);
    bus.enable = 1'b1;
    push("cont_arm", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 30; k++)
      push("cont_run", 1'b1, 1'b0, (k % 10) >= 5, (k % 10) >= 1 && (k % 10) <= 3);
    drain();
    bus.enable = 1'b0;
    push("cont_off", 1'b0, 1'b0, 1'b0, 1'b0);
    push("cont_off", 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    // burst of three, then parked
    load(1, 0, 3, 8, 2, 0, 0, 0);
    bus.enable = 1'b1;
    push("burst_arm", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 24; k++) push_run("burst_run", k, 8, 2);
    push("burst_done", 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) push("burst_hold", 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    bus.enable = 1'b0;
    tick();
    // external sync start, second sync ignored
    load(0, 1, 1, 6, 2, 0, 0, 0);
    bus.enable = 1'b1;
    push("sync_arm", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) push("sync_wait", 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    bus.sync_in = 1'b1;
    push_run("sync_k0", 0, 6, 2);
    drain();
    bus.sync_in = 1'b0;
    for (int k = 1; k < 4; k++) push_run("sync_run", k, 6, 2);
    drain();
    bus.sync_in = 1'b1;
    push_run("sync_again", 4, 6, 2);
    drain();
    bus.sync_in = 1'b0;
    for (int k = 5; k < 21; k++) push_run("sync_run", k, 6, 2);
    drain();
    bus.enable = 1'b0;
    tick();
    // period change mid-period, then rejected loads
    load(0, 0, 1, 10, 3, 0, 0, 0);
    bus.enable = 1'b1;
    push("upd_arm", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) push("upd_run", 1'b1, 1'b0, 1'b0, exp4(k));
    drain();
    set_cfg(0, 0, 1, 20, 3, 0, 0, 0);
    bus.load_config = 1'b1;
    push("upd_run", 1'b1, 1'b0, 1'b0, exp4(5));
    drain();
    bus.load_config = 1'b0;
    for (int k = 6; k < 36; k++) push("upd_run", 1'b1, 1'b0, 1'b0, exp4(k));
    drain();
    set_cfg(0, 0, 1, 1, 3, 0, 0, 0);
    bus.load_config = 1'b1;
    push("rej_run", 1'b1, 1'b0, 1'b0, exp4(36));
    drain();
    bus.load_config = 1'b0;
    check("rej_per_err", 32'(bus.cfg_error), 32'h1);
    for (int k = 37; k < 46; k++) push("rej_run", 1'b1, 1'b0, 1'b0, exp4(k));
    drain();
    set_cfg(3, 0, 1, 10, 3, 0, 0, 0);
    bus.load_config = 1'b1;
    push("rej_run", 1'b1, 1'b0, 1'b0, exp4(46));
    drain();
    bus.load_config = 1'b0;
    check("rej_mode_err", 32'(bus.cfg_error), 32'h1);
    set_cfg(1, 0, 0, 10, 3, 0, 0, 0);
    bus.load_config = 1'b1;
    push("rej_run", 1'b1, 1'b0, 1'b0, exp4(47));
    drain();
    bus.load_config = 1'b0;
    check("rej_burst_err", 32'(bus.cfg_error), 32'h1);
    for (int k = 48; k < 56; k++) push("rej_run", 1'b1, 1'b0, 1'b0, exp4(k));
    drain();
    set_cfg(0, 0, 1, 20, 3, 0, 0, 0);
    bus.load_config = 1'b1;
    push("ok_run", 1'b1, 1'b0, 1'b0, exp4(56));
    drain();
    bus.load_config = 1'b0;
    check("ok_err_clr", 32'(bus.cfg_error), 32'h0);
    for (int k = 57; k < 76; k++) push("ok_run", 1'b1, 1'b0, 1'b0, exp4(k));
    drain();
    bus.enable = 1'b0;
    tick();
    // width 0 and width==period, then async reset mid-pulse
    load(0, 0, 1, 5, 0, 5, 0, 0);
    bus.enable = 1'b1;
    push("edge_arm", 1'b0, 1'b0, 1'b0, 1'b0);
    push("edge_k0", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k < 13; k++) push("edge_run", 1'b1, 1'b0, 1'b1, 1'b0);
    drain();
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst", 32'(obs), 32'h0);
    bus.enable = 1'b0;
    tick();
    check("rst_hold", 32'(obs), 32'h0);
    resetn = 1'b1;
    tick();
    // one-shot
    load(2, 0, 1, 4, 1, 0, 0, 0);
    bus.enable = 1'b1;
    push("one_arm", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) push_run("one_run", k, 4, 1);
    push("one_done", 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) push("one_hold", 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
